dmem_bus_arbiter: RTL and testbench
===================================

Name: dmem_bus_arbiter

Overview:
- Shares the single DataMemory port between two requesters: M0 (CPU load/store path) and M1 (loader/debug DMA engine that preloads or inspects memory).
- Sits between the requesters and DataMemory.
- Drives the memory-side address bus, write-data bus and 3-bit control bus.
- Returns read data to whichever requester issued the read.
- Uses round-robin ownership with a hold limit, an optional M1 lock for bursts, and a tagged read-return pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; matches the CPU bit width.
- READ_LAT, 1, cycles from an accepted read to mem_rdata valid; legal range 0..4.
- MAX_HOLD, 8, maximum consecutive grants to one owner while the other requester is waiting.

Ports:
- InputClk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  M0 request valid.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  ADDR_W  M0 address.
- m0_wdata  in  DATA_W  M0 write data.
- m0_gnt  out  1  M0 request accepted this cycle.
- m0_rvalid  out  1  M0 read data valid.
- m0_rdata  out  DATA_W  M0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the M0 set, for M1.
- m1_lock  in  1  M1 holds ownership while asserted; the hold limit is ignored.
- mem_addr  out  ADDR_W  DataMemory address bus.
- mem_wdata  out  DATA_W  DataMemory write data.
- mem_ctrl  out  3  control bus: bit1 = read enable, bit2 = write enable, bit0 = 0.
- mem_rdata  in  DATA_W  DataMemory read data.
- busy  out  1  a read is outstanding or ownership is held.

Behaviour:
- Reset (async, immediate): state IDLE; hold counter 0; last-owner pointer = M1, so M0 wins first; tag pipeline cleared. All outputs are 0.
- FSM states: IDLE, OWN0, OWN1. The state register is sequential. Grants are combinational from the state and the current requests.
- IDLE:
  - Only m0_req: grant M0, next state OWN0.
  - Only m1_req: grant M1, next state OWN1.
  - Both: grant the requester that is not the last owner.
- OWNx, owner still requesting and the other idle: keep granting; the hold counter saturates.
- OWNx, both requesting:
  - Owner keeps the grant until the hold counter reaches MAX_HOLD.
  - On the cycle after the MAX_HOLD-th consecutive grant, ownership moves to the other requester and the counter resets to 0.
- OWNx, owner drops its request: same cycle, grant the other requester if it is requesting (next state OWNy); otherwise next state IDLE.
- m1_lock=1 while in OWN1: stay in OWN1 regardless of m0_req or the counter. M0 is starved by design.
- m1_lock=1 while in IDLE: M1 has priority.
- Exactly one grant per cycle at most.
  - mem_ctrl = {we&gnt, ~we&gnt, 0} for the granted master.
  - mem_addr / mem_wdata are muxed from the granted master. They are 0 when there is no grant, so the bus is quiet.
- Writes complete on the granting cycle. There is no response.
- Read return:
  - Each granted read pushes {valid, id} into a READ_LAT-deep shift register.
  - On exit, assert mx_rvalid for one cycle with mx_rdata = mem_rdata; the other master's rdata is 0.
  - READ_LAT=0: rvalid/rdata are combinational in the grant cycle.
  - Reads are pipelined back-to-back, one per cycle.
  - A switch of owner does not wait for outstanding reads; tags keep the returns correct.
- busy = state≠IDLE or any tag valid.
- Reset mid-transfer: outstanding reads are discarded and no rvalid is produced. Requesters must reissue.
- Requesters hold req/we/addr/wdata stable until gnt.

Decomposition:
- Shared package/defs header holds:
  - state encodings IDLE=2'd0, OWN0=2'd1, OWN1=2'd2;
  - control bit indices CTRL_RD=1, CTRL_WR=2;
  - master IDs ID_M0=0, ID_M1=1.
- Sub-module rd_tag_pipe: READ_LAT-deep valid+id shift register with clear. It is instantiated once.

Test Plan:
1. After reset, m0 read addr 0x10 with memory[0x10]=0xDEADBEEF, READ_LAT=1 -> m0_gnt at cycle 0, mem_ctrl=3'b010, m0_rvalid and m0_rdata=0xDEADBEEF at cycle 1, m1_rvalid=0.
2. Both request continuously from IDLE, MAX_HOLD=8 -> M0 granted 8 consecutive cycles, then M1 for 8, alternating. Never two grants in one cycle.
3. m1_lock=1 with m1 writing 0x100..0x11C (8 words) while m0_req held -> 8 M1 grants, no m0_gnt. m0 granted the cycle after lock and m1_req drop.
4. Alternating reads M0 addr 0x0, M1 addr 0x4, M0 addr 0x8 on successive cycles, READ_LAT=2 -> each rvalid returns on the correct master two cycles later, with data matching memory.
5. Write M0 addr 0x20 data 0x12345678, then read back via M1 -> M1 receives 0x12345678. mem_ctrl=3'b100 on the write cycle.
6. Assert rst while a read is in flight -> all outputs 0 immediately. No rvalid appears after reset release. FSM is in IDLE and M0 wins the first contention.

Source files
------------

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared encodings for the DataMemory bus arbiter: FSM states, control-bus bit
// positions and requester identifiers carried through the read-return tags.
package dmem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam int CTRL_RD = 1;
    localparam int CTRL_WR = 2;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/dmem_bus_arbiter_rd_tag_pipe.sv
// Delay line of {valid, requester id} tags that follows each accepted read
// until its data appears on the memory read bus; cleared by the async reset.
module rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_valid_i,
    input  logic push_id_i,
    output logic pop_valid_o,
    output logic pop_id_o,
    output logic busy_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unusedClkRst;
            assign unusedClkRst = clk_i ^ rst_i;
            assign pop_valid_o  = push_valid_i;
            assign pop_id_o     = push_id_i;
            assign busy_o       = 1'b0;
        end else begin : g_pipe
            logic [DEPTH-1:0] valid_q;
            logic [DEPTH-1:0] id_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= '0;
                    id_q    <= '0;
                end else begin
                    valid_q[0] <= push_valid_i;
                    id_q[0]    <= push_id_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        id_q[i]    <= id_q[i-1];
                    end
                end
            end

            assign pop_valid_o = valid_q[DEPTH-1];
            assign pop_id_o    = id_q[DEPTH-1];
            assign busy_o      = |valid_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master DataMemory arbiter: round-robin ownership with a hold limit, an M1
// burst lock, and tagged read returns routed back to the issuing master.
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              InputClk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_ctrl,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int              HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d, holdNext;
    logic              lastOwner_q, lastOwner_d;
    logic              gnt0Raw, gnt1Raw, anyGnt, gntWe, holdLimit;
    logic              popValid, popId, tagsBusy;

    assign holdLimit = (holdCnt_q >= HOLD_MAX);
    assign holdNext  = (holdCnt_q == HOLD_MAX) ? holdCnt_q : holdCnt_q + HOLD_W'(1);

    always_ff @(posedge InputClk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            holdCnt_q   <= '0;
            lastOwner_q <= ID_M1;
        end else begin
            state_q     <= state_d;
            holdCnt_q   <= holdCnt_d;
            lastOwner_q <= lastOwner_d;
        end
    end

    // The owner only loses the bus to a waiting requester once its run hits the limit.
    always_comb begin
        state_d     = state_q;
        holdCnt_d   = holdCnt_q;
        lastOwner_d = lastOwner_q;
        gnt0Raw     = 1'b0;
        gnt1Raw     = 1'b0;
        case (state_q)
            IDLE: begin
                if (m1_lock && m1_req)    gnt1Raw = 1'b1;
                else if (m0_req && m1_req) begin
                    if (lastOwner_q == ID_M0) gnt1Raw = 1'b1;
                    else                      gnt0Raw = 1'b1;
                end
                else if (m0_req)          gnt0Raw = 1'b1;
                else if (m1_req)          gnt1Raw = 1'b1;
            end
            OWN0: begin
                if (m0_req && !(m1_req && holdLimit)) gnt0Raw = 1'b1;
                else if (m1_req)                      gnt1Raw = 1'b1;
            end
            OWN1: begin
                if (m1_lock)                                gnt1Raw = m1_req;
                else if (m1_req && !(m0_req && holdLimit))  gnt1Raw = 1'b1;
                else if (m0_req)                            gnt0Raw = 1'b1;
            end
            default: ;
        endcase

        if (gnt0Raw) begin
            state_d     = OWN0;
            lastOwner_d = ID_M0;
            holdCnt_d   = (state_q == OWN0) ? holdNext : HOLD_W'(1);
        end else if (gnt1Raw) begin
            state_d     = OWN1;
            lastOwner_d = ID_M1;
            holdCnt_d   = (state_q == OWN1) ? holdNext : HOLD_W'(1);
        end else if (!(state_q == OWN1 && m1_lock)) begin
            state_d   = IDLE;
            holdCnt_d = '0;
        end
    end

    // Grants are combinational, so they are masked while reset is asserted.
    assign m0_gnt = gnt0Raw & ~rst;
    assign m1_gnt = gnt1Raw & ~rst;
    assign anyGnt = m0_gnt | m1_gnt;
    assign gntWe  = m0_gnt ? m0_we : m1_we;

    always_comb begin
        mem_ctrl          = '0;
        mem_ctrl[CTRL_WR] = anyGnt & gntWe;
        mem_ctrl[CTRL_RD] = anyGnt & ~gntWe;
    end

    assign mem_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : '0);
    assign mem_wdata = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : '0);

    rd_tag_pipe #(
        .DEPTH (READ_LAT)
    ) u_tagPipe (
        .clk_i        (InputClk),
        .rst_i        (rst),
        .push_valid_i (anyGnt & ~gntWe),
        .push_id_i    (m1_gnt),
        .pop_valid_o  (popValid),
        .pop_id_o     (popId),
        .busy_o       (tagsBusy)
    );

    assign m0_rvalid = popValid & (popId == ID_M0);
    assign m1_rvalid = popValid & (popId == ID_M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
    assign busy      = (state_q != IDLE) | tagsBusy;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: directed scenarios then constrained-random traffic,
// every cycle compared against a rule-level arbitration and memory model.
module tb_dmem_bus_arbiter;

    localparam int LAT  = 2;
    localparam int HOLD = 8;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xact_t;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rdRet_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_ctrl;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    xact_t       cur0, cur1;
    logic        curLock;
    int          owner, run, last, cycleNo;
    rdRet_t      pendQ[$];
    bit   [31:0] modelMem [256];
    bit   [31:0] tbMem [256];
    bit   [31:0] rdPipe [LAT];

    dmem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .READ_LAT(LAT), .MAX_HOLD(HOLD)
    ) dut (
        .InputClk(clock), .rst(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_lock(m1_lock),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // DataMemory stand-in; idle slots carry random junk so unmasked rdata shows up.
    always @(posedge clock) begin
        if (mem_ctrl[2]) tbMem[mem_addr[9:2]] <= mem_wdata;
        rdPipe[0] <= mem_ctrl[1] ? tbMem[mem_addr[9:2]] : $urandom;
        for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign mem_rdata = rdPipe[LAT-1];

    function automatic xact_t noX();
        return '{req: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0};
    endfunction

    function automatic xact_t rdX(input logic [31:0] a);
        return '{req: 1'b1, we: 1'b0, addr: a, wdata: 32'h0};
    endfunction

    function automatic xact_t wrX(input logic [31:0] a, input logic [31:0] d);
        return '{req: 1'b1, we: 1'b1, addr: a, wdata: d};
    endfunction

    function automatic xact_t randX();
        xact_t x;
        x.req   = ($urandom_range(0, 9) < 7);
        x.we    = 1'($urandom_range(0, 1));
        x.addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        x.wdata = $urandom;
        return x;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setInputs(input xact_t x0, input xact_t x1, input logic lk);
        cur0 = x0; cur1 = x1; curLock = lk;
        m0_req = x0.req; m0_we = x0.we; m0_addr = x0.addr; m0_wdata = x0.wdata;
        m1_req = x1.req; m1_we = x1.we; m1_addr = x1.addr; m1_wdata = x1.wdata;
        m1_lock = lk;
    endtask

    task automatic applyStimulus(input xact_t x0, input xact_t x1, input logic lk);
        @(negedge clock);
        setInputs(x0, x1, lk);
        #2;
    endtask

    task automatic resetModel();
        owner = -1; run = 0; last = 1;
        pendQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_m0_gnt"}, m0_gnt, 0);
        checkVal({tag, "_m1_gnt"}, m1_gnt, 0);
        checkVal({tag, "_m0_rvalid"}, m0_rvalid, 0);
        checkVal({tag, "_m1_rvalid"}, m1_rvalid, 0);
        checkVal({tag, "_m0_rdata"}, m0_rdata, 0);
        checkVal({tag, "_m1_rdata"}, m1_rdata, 0);
        checkVal({tag, "_mem_addr"}, mem_addr, 0);
        checkVal({tag, "_mem_wdata"}, mem_wdata, 0);
        checkVal({tag, "_mem_ctrl"}, mem_ctrl, 0);
        checkVal({tag, "_busy"}, busy, 0);
    endtask

    task automatic pulseReset();
        @(negedge clock);
        setInputs(rdX(32'h4), rdX(32'h8), 1'b0);
        reset = 1'b1;
        #1;
        checkAllZero("rst_pulse");
        setInputs(noX(), noX(), 1'b0);
        #1;
        reset = 1'b0;
        resetModel();
    endtask

    // Who should get the bus this cycle, from the ownership rules alone.
    function automatic int predictGrant();
        bit r0, r1, ownReq, othReq;
        r0 = cur0.req; r1 = cur1.req;
        if (owner == -1) begin
            if (r1 && curLock) return 1;
            if (r0 && r1)      return 1 - last;
            if (r0)            return 0;
            if (r1)            return 1;
            return -1;
        end
        if (owner == 1 && curLock) return r1 ? 1 : -1;
        ownReq = (owner == 0) ? r0 : r1;
        othReq = (owner == 0) ? r1 : r0;
        if (ownReq && (!othReq || run < HOLD)) return owner;
        if (othReq) return 1 - owner;
        return -1;
    endfunction

    task automatic checkOutput(output int g);
        bit          expBusy;
        logic        e0v, e1v;
        logic [31:0] e0d, e1d, ea, ew;
        logic [2:0]  ec;
        rdRet_t      r;
        xact_t       gx;
        g = predictGrant();
        expBusy = (owner != -1);
        foreach (pendQ[i]) if (pendQ[i].due >= cycleNo) expBusy = 1'b1;
        e0v = 0; e1v = 0; e0d = 0; e1d = 0;
        while (pendQ.size() != 0 && pendQ[0].due <= cycleNo) begin
            r = pendQ.pop_front();
            if (r.id == 0) begin e0v = 1; e0d = r.data; end
            else           begin e1v = 1; e1d = r.data; end
        end
        ea = 0; ew = 0; ec = 0; gx = noX();
        if (g >= 0) begin
            gx = (g == 0) ? cur0 : cur1;
            ea = gx.addr; ew = gx.wdata; ec = gx.we ? 3'b100 : 3'b010;
        end
        checkVal("m0_gnt", m0_gnt, g == 0);
        checkVal("m1_gnt", m1_gnt, g == 1);
        checkVal("mem_ctrl", mem_ctrl, ec);
        checkVal("mem_addr", mem_addr, ea);
        checkVal("mem_wdata", mem_wdata, ew);
        checkVal("m0_rvalid", m0_rvalid, e0v);
        checkVal("m1_rvalid", m1_rvalid, e1v);
        checkVal("m0_rdata", m0_rdata, e0d);
        checkVal("m1_rdata", m1_rdata, e1d);
        checkVal("busy", busy, expBusy);
        if (g >= 0) begin
            if (gx.we) modelMem[gx.addr[9:2]] = gx.wdata;
            else pendQ.push_back('{due: cycleNo + LAT, id: g, data: modelMem[gx.addr[9:2]]});
            run   = (g == owner) ? run + 1 : 1;
            owner = g;
            last  = g;
        end else if (!(owner == 1 && curLock)) begin
            owner = -1;
            run   = 0;
        end
        cycleNo++;
    endtask

    initial begin
        int    g, cnt0, cnt1;
        xact_t x0, x1;
        logic  lk;

        cycleNo = 0;
        resetModel();
        reset = 1'b1;
        setInputs(rdX(32'h10), rdX(32'h14), 1'b1);
        #3;
        checkAllZero("rst_init");
        setInputs(noX(), noX(), 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Loader preloads memory through M1.
        applyStimulus(noX(), wrX(32'h10, 32'hDEADBEEF), 1'b0); checkOutput(g);
        applyStimulus(noX(), wrX(32'h0, 32'hA0000000), 1'b0);  checkOutput(g);
        applyStimulus(noX(), wrX(32'h4, 32'hA0000004), 1'b0);  checkOutput(g);
        applyStimulus(noX(), wrX(32'h8, 32'hA0000008), 1'b0);  checkOutput(g);
        applyStimulus(noX(), noX(), 1'b0); checkOutput(g);

        pulseReset();
        applyStimulus(rdX(32'h10), noX(), 1'b0); checkOutput(g);
        checkVal("t1_m0_gnt", m0_gnt, 1);
        checkVal("t1_ctrl", mem_ctrl, 3'b010);
        for (int i = 0; i < LAT; i++) begin
            applyStimulus(noX(), noX(), 1'b0); checkOutput(g);
        end
        checkVal("t1_m0_rvalid", m0_rvalid, 1);
        checkVal("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        checkVal("t1_m1_rvalid", m1_rvalid, 0);

        pulseReset();
        for (int i = 0; i < 4 * HOLD; i++) begin
            applyStimulus(rdX(32'h40), rdX(32'h44), 1'b0); checkOutput(g);
            checkVal("t2_rr_m0_gnt", m0_gnt, ((i / HOLD) % 2) == 0);
            checkVal("t2_one_gnt", m0_gnt & m1_gnt, 0);
        end
        applyStimulus(noX(), noX(), 1'b0); checkOutput(g);

        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(rdX(32'h40), wrX(32'h100 + 4 * i, 32'hC0DE0000 + i), 1'b1);
            checkOutput(g);
            cnt0 += int'(m0_gnt); cnt1 += int'(m1_gnt);
        end
        checkVal("t3_m1_grants", cnt1, 8);
        checkVal("t3_m0_grants", cnt0, 0);
        applyStimulus(rdX(32'h40), noX(), 1'b0); checkOutput(g);
        checkVal("t3_m0_after_lock", m0_gnt, 1);
        repeat (3) begin applyStimulus(noX(), noX(), 1'b0); checkOutput(g); end

        applyStimulus(rdX(32'h0), noX(), 1'b0); checkOutput(g);
        applyStimulus(noX(), rdX(32'h4), 1'b0); checkOutput(g);
        applyStimulus(rdX(32'h8), noX(), 1'b0); checkOutput(g);
        checkVal("t4_ret0_m0", m0_rdata, 32'hA0000000);
        applyStimulus(noX(), noX(), 1'b0); checkOutput(g);
        checkVal("t4_ret1_m1", m1_rdata, 32'hA0000004);
        checkVal("t4_ret1_m0v", m0_rvalid, 0);
        applyStimulus(noX(), noX(), 1'b0); checkOutput(g);
        checkVal("t4_ret2_m0", m0_rdata, 32'hA0000008);

        applyStimulus(wrX(32'h20, 32'h12345678), noX(), 1'b0); checkOutput(g);
        checkVal("t5_wr_ctrl", mem_ctrl, 3'b100);
        applyStimulus(noX(), rdX(32'h20), 1'b0); checkOutput(g);
        for (int i = 0; i < LAT; i++) begin
            applyStimulus(noX(), noX(), 1'b0); checkOutput(g);
        end
        checkVal("t5_m1_rdata", m1_rdata, 32'h12345678);

        applyStimulus(rdX(32'h10), noX(), 1'b0); checkOutput(g);
        @(negedge clock);
        setInputs(rdX(32'h4), rdX(32'h8), 1'b0);
        reset = 1'b1;
        #1;
        checkAllZero("t6_midreset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        setInputs(noX(), noX(), 1'b0);
        reset = 1'b0;
        resetModel();
        applyStimulus(rdX(32'h4), rdX(32'h8), 1'b0); checkOutput(g);
        checkVal("t6_m0_wins", m0_gnt, 1);
        repeat (LAT + 2) begin
            applyStimulus(noX(), noX(), 1'b0); checkOutput(g);
        end

        x0 = noX(); x1 = noX(); lk = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!x0.req) x0 = randX();
            if (!x1.req) x1 = randX();
            if ($urandom_range(0, 15) == 0) lk = ~lk;
            applyStimulus(x0, x1, lk); checkOutput(g);
            if (g == 0) x0 = noX();
            if (g == 1) x1 = noX();
        end
        repeat (LAT + 2) begin
            applyStimulus(noX(), noX(), 1'b0); checkOutput(g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
